uart_tx_arbiter: RTL and testbench

//  Round-robin scheduler sharing one uart_tx (8-P-1) between NUM_REQ byte-stream requesters.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default timeouts for the uart_tx round-robin arbiter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD
  } arb_state_t;

  localparam int DEF_HOLD_TIMEOUT = 64;
  localparam int DEF_BUSY_TIMEOUT = 4;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && valid[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte streams, with
// packet lock, hold-idle release and busy-handshake watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_TIMEOUT = DEF_HOLD_TIMEOUT,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*8-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   tx_start_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_busy_i,
  input  logic                   tx_error_i,
  output logic                   abort_o,
  output logic                   err_o
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int HCNT_W = $clog2(HOLD_TIMEOUT + 1);
  localparam int BCNT_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t          state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    owner;
  logic                lock;
  logic [HCNT_W-1:0]   hold_cnt;
  logic [BCNT_W-1:0]   busy_cnt;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;
  logic [7:0]          req_byte [NUM_REQ];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) req_byte[k] = req_data_i[8*k +: 8];
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .valid (req_valid_i),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Ready only in IDLE (arbitration) or HOLD (locked owner); never while a byte is in flight.
  always_comb begin
    req_ready_o = '0;
    if (!rst) begin
      if (state == IDLE)      req_ready_o = pick_grant;
      else if (state == HOLD) req_ready_o = grant_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      lock       <= 1'b0;
      hold_cnt   <= '0;
      busy_cnt   <= '0;
      grant_o    <= '0;
      tx_start_o <= 1'b0;
      tx_data_o  <= '0;
      abort_o    <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      tx_start_o <= 1'b0;
      abort_o    <= 1'b0;
      // A watchdog expiry below overrides this, so a coincident tx_error_i gives one pulse.
      err_o      <= tx_error_i;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            owner      <= pick_idx;
            grant_o    <= pick_grant;
            tx_data_o  <= req_byte[pick_idx];
            lock       <= ~req_last_i[pick_idx];
            tx_start_o <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          busy_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy_i) begin
            state <= WAIT_DONE;
          end else if (busy_cnt == BCNT_W'(BUSY_TIMEOUT - 1)) begin
            err_o   <= 1'b1;
            grant_o <= '0;
            lock    <= 1'b0;
            rr_ptr  <= next_ptr(owner);
            state   <= IDLE;
          end else begin
            busy_cnt <= busy_cnt + BCNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_i) begin
            if (lock) begin
              hold_cnt <= '0;
              state    <= HOLD;
            end else begin
              grant_o <= '0;
              rr_ptr  <= next_ptr(owner);
              state   <= IDLE;
            end
          end
        end
        HOLD: begin
          if (req_valid_i[owner]) begin
            tx_data_o  <= req_byte[owner];
            lock       <= ~req_last_i[owner];
            hold_cnt   <= '0;
            tx_start_o <= 1'b1;
            state      <= START;
          end else if (hold_cnt == HCNT_W'(HOLD_TIMEOUT - 1)) begin
            abort_o <= 1'b1;
            grant_o <= '0;
            lock    <= 1'b0;
            rr_ptr  <= next_ptr(owner);
            state   <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx busy responder (110-clk frame).
module tb_uart_tx_arbiter;

  localparam int FRAME = 110;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        tx_error;
  logic        abort;
  logic        err;

  int   n_vec = 0;
  int   n_bad = 0;
  logic busy_dead = 1'b0;
  int   bcnt = 0;
  logic [3:0] log_grant [$];
  logic [7:0] log_data  [$];

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .HOLD_TIMEOUT (64),
    .BUSY_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .grant_o     (grant),
    .tx_start_o  (tx_start),
    .tx_data_o   (tx_data),
    .tx_busy_i   (tx_busy),
    .tx_error_i  (tx_error),
    .abort_o     (abort),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: goes busy for one frame after each start pulse and logs what was started.
  always @(negedge clk) begin
    if (rst) begin
      tx_busy = 1'b0;
      bcnt    = 0;
    end else begin
      if (tx_start) begin
        log_grant.push_back(grant);
        log_data.push_back(tx_data);
      end
      if (tx_start && !busy_dead) begin
        tx_busy = 1'b1;
        bcnt    = FRAME;
      end else if (bcnt > 0) begin
        bcnt = bcnt - 1;
        if (bcnt == 0) tx_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int idx, input logic [7:0] d, input logic l);
    req_valid[idx]       = 1'b1;
    req_data[8*idx +: 8] = d;
    req_last[idx]        = l;
  endtask

  task automatic accept_byte(input string tag, input int idx, input logic [7:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    set_byte(idx, d, l);
    #1;
    for (int k = 0; k < 400; k++) begin
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(ok), 32'd1);
    if (ok) tick();
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_grant_zero(input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (grant == 4'b0000) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_log(input string tag, input int n);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (log_grant.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_busy(input string tag, input logic level);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (tx_busy == level) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = '0;
    req_last  = '0;
    tx_error  = 1'b0;

    // Reset: everything quiet, ready held low even with all requesters valid.
    repeat (3) tick();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_start", 32'(tx_start), 32'h0);
    chk("rst_data", 32'(tx_data), 32'h0);
    chk("rst_abort", 32'(abort), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    req_valid = 4'b0000;
    rst = 1'b0;
    tick();

    // tx_error_i in IDLE: one err pulse the following cycle.
    tx_error = 1'b1;
    tick();
    tx_error = 1'b0;
    chk("txerr_pulse", 32'(err), 32'h1);
    tick();
    chk("txerr_clear", 32'(err), 32'h0);

    // Single byte from req0.
    set_byte(0, 8'hA5, 1'b1);
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    chk("single_start", 32'(tx_start), 32'h1);
    chk("single_data", 32'(tx_data), 32'hA5);
    chk("single_grant", 32'(grant), 32'h1);
    tick();
    chk("single_start_1cyc", 32'(tx_start), 32'h0);
    req_valid = 4'b0010;
    #1;
    chk("single_busy_noready", 32'(req_ready), 32'h0);
    req_valid = 4'b0000;
    wait_grant_zero("single_release");
    // rr_ptr is now 1: with req0 and req1 valid, req1 must be offered.
    req_valid = 4'b0011;
    #1;
    chk("single_ptr", 32'(req_ready), 32'h2);
    req_valid = 4'b0000;
    tick();

    // Busy timeout on req3: START + 4 WAIT_BUSY cycles, with a coincident tx_error_i.
    busy_dead = 1'b1;
    accept_byte("bto_accept", 3, 8'h5A, 1'b1);
    chk("bto_start", 32'(tx_start), 32'h1);
    n = 11;
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) tx_error = 1'b1;
      tick();
      tx_error = 1'b0;
      if (err) begin
        n = k;
        break;
      end
    end
    chk("bto_latency", 32'(n), 32'd5);
    chk("bto_grant", 32'(grant), 32'h0);
    tick();
    chk("bto_err_single", 32'(err), 32'h0);
    busy_dead = 1'b0;

    // Fairness: all four valid, last=1 each; rr_ptr is 0 after the req3 release.
    log_grant.delete();
    log_data.delete();
    for (int i = 0; i < 4; i++) set_byte(i, 8'(8'h10 + i), 1'b1);
    wait_log("fair_log", 5);
    req_valid = 4'b0000;
    wait_grant_zero("fair_release");
    for (int i = 0; i < 5 && i < log_grant.size(); i++) begin
      chk($sformatf("fair_grant%0d", i), 32'(log_grant[i]), 32'(4'b0001 << (i % 4)));
      chk($sformatf("fair_data%0d", i), 32'(log_data[i]), 32'(8'h10 + (i % 4)));
    end

    // Lock: req1 sends 11,22,33(last) while req2 waits; rr_ptr is 1.
    log_grant.delete();
    log_data.delete();
    set_byte(2, 8'h77, 1'b1);
    accept_byte("lock_b0", 1, 8'h11, 1'b0);
    req_valid[2] = 1'b1;
    accept_byte("lock_b1", 1, 8'h22, 1'b0);
    req_valid[2] = 1'b1;
    accept_byte("lock_b2", 1, 8'h33, 1'b1);
    req_valid[2] = 1'b1;
    wait_log("lock_log", 4);
    req_valid = 4'b0000;
    wait_grant_zero("lock_release");
    if (log_grant.size() >= 4) begin
      chk("lock_g0", 32'(log_grant[0]), 32'h2);
      chk("lock_d0", 32'(log_data[0]), 32'h11);
      chk("lock_g1", 32'(log_grant[1]), 32'h2);
      chk("lock_d1", 32'(log_data[1]), 32'h22);
      chk("lock_g2", 32'(log_grant[2]), 32'h2);
      chk("lock_d2", 32'(log_data[2]), 32'h33);
      chk("lock_g3", 32'(log_grant[3]), 32'h4);
      chk("lock_d3", 32'(log_data[3]), 32'h77);
    end

    // Hold timeout: req3 sends 0x44 without last and goes silent; req0 pending.
    log_grant.delete();
    log_data.delete();
    accept_byte("hold_accept", 3, 8'h44, 1'b0);
    set_byte(0, 8'h99, 1'b1);
    wait_busy("hold_busy_hi", 1'b1);
    wait_busy("hold_busy_lo", 1'b0);
    n = 81;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 10) chk("hold_ready_owner", 32'(req_ready), 32'h8);
      if (abort) begin
        n = k;
        break;
      end
    end
    chk("hold_latency", 32'(n), 32'd64);
    chk("hold_grant", 32'(grant), 32'h0);
    tick();
    chk("hold_abort_1cyc", 32'(abort), 32'h0);
    wait_log("hold_log", 2);
    req_valid = 4'b0000;
    if (log_grant.size() >= 2) begin
      chk("hold_next_grant", 32'(log_grant[1]), 32'h1);
      chk("hold_next_data", 32'(log_data[1]), 32'h99);
    end
    wait_grant_zero("hold_release");

    // Reset mid-frame during the 2nd byte of a locked packet from req1.
    accept_byte("mid_b0", 1, 8'hB1, 1'b0);
    accept_byte("mid_b1", 1, 8'hB2, 1'b0);
    repeat (20) tick();
    rst = 1'b1;
    req_valid = 4'b0100;
    set_byte(2, 8'hC3, 1'b1);
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    chk("mid_grant", 32'(grant), 32'h0);
    chk("mid_start", 32'(tx_start), 32'h0);
    chk("mid_data", 32'(tx_data), 32'h0);
    chk("mid_abort", 32'(abort), 32'h0);
    chk("mid_err", 32'(err), 32'h0);
    rst = 1'b0;
    #1;
    chk("mid_nolock_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    chk("mid_new_grant", 32'(grant), 32'h4);
    chk("mid_new_data", 32'(tx_data), 32'hC3);
    wait_grant_zero("mid_release");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
